// File: rtl/add_sub_seq_if.sv
// Request/response bundle for the chunk-serial adder/subtractor.
//
// Handshake: both channels use strict valid/ready. A transfer happens on the
// rising edge where valid && ready are both high. A producer holds valid and
// its payload stable until that edge. Ready may depend combinationally on
// state, but valid never depends on ready.
interface add_sub_seq_if #(
    parameter int WIDTH = 32
);
    // request channel
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin_ext;
    // response channel
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, op, a, b, cin_ext, out_ready,
        input  in_ready, out_valid, result, cout, ovf, zero
    );

    modport slave (
        input  in_valid, op, a, b, cin_ext, out_ready,
        output in_ready, out_valid, result, cout, ovf, zero
    );
endinterface

// File: rtl/add_sub_seq.sv
// Chunk-serial ADD/SUB/ADC/SBC unit. One WIDTH-bit operation is accepted,
// then CHUNK bits are summed per cycle from the LSB chunk upward. The carry
// ripples through a register between chunks. Flags are produced on the last
// chunk. op encoding: bit0 selects B inversion; bit1 selects the external
// carry as the carry-in instead of the bit0-derived constant.
module add_sub_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic       clk,
    input  logic       reset,
    add_sub_seq_if.slave bus,
    output logic [1:0] dbg_state_o
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0]    LAST_IDX   = CW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;          // B already inverted for SUB/SBC
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;

    logic [31:0]      sh;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   sum;
    logic             c_into_msb;
    logic [WIDTH-1:0] result_merged;

    // Current chunk slice, its CHUNK+1-bit sum, and the result with it merged in.
    always_comb begin
        sh            = 32'(cnt_q) * 32'(CHUNK);
        a_chunk       = CHUNK'(a_q >> sh);
        b_chunk       = CHUNK'(b_q >> sh);
        sum           = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        // Carry into the top bit recovered from the top bit's sum and operands.
        c_into_msb    = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ sum[CHUNK-1];
        result_merged = (result_q & ~(CHUNK_MASK << sh)) |
                        (WIDTH'(sum[CHUNK-1:0]) << sh);
    end

    // Next-state and datapath update for IDLE/RUN/DONE.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.op[0] ? ~bus.b : bus.b;
                    carry_d = bus.op[1] ? bus.cin_ext : bus.op[0];
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d = result_merged;
                carry_d  = sum[CHUNK];
                if (cnt_q == LAST_IDX) begin
                    cout_d      = sum[CHUNK];
                    ovf_d       = c_into_msb ^ sum[CHUNK];
                    zero_d      = (result_merged == '0);
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = !reset && (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
    assign dbg_state_o   = state_q;
endmodule
